quad_encoder_if: RTL and testbench
==================================

// Module: quad_encoder_if
// PURPOSE
//  Front end for one motor's hall/quadrature encoder. Sits directly upstream of motor_ctrl.
//  - Synchronises raw sa/sb and glitch-filters them.
//  - Decodes x4 quadrature into a signed rotation count (feeds motor_ctrl rot_cnt path).
//  - Measures per-window velocity (feeds the PID).
//  - Flags illegal transitions.
//  Instantiated twice at top level, one per motor; sa/sb order per wiring, INVERT per side.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock in Hz (informational; documents the VEL_WINDOW time base)
//  FILTER_LEN  4           consecutive identical synced samples needed to accept a level (>=1)
//  VEL_WINDOW  100_000     velocity window in clk cycles (2 ms at 50 MHz), >=2
//  CNT_W       32          width of rot_cnt / rot_v
//  INVERT      0           1: negate count direction (mirrored motor)
// PORTS
//  clk          in   1      system clock (50 MHz)
//  rst          in   1      synchronous reset, active high
//  sa           in   1      encoder channel A, asynchronous
//  sb           in   1      encoder channel B, asynchronous
//  err_clr      in   1      clears step_err (and err_cnt)
//  rot_cnt      out  CNT_W  signed accumulated steps, two's-complement wrap
//  rot_v        out  CNT_W  signed steps counted in last completed window
//  rot_v_valid  out  1      1-cycle pulse when rot_v updates
//  dir          out  1      direction of last legal step: 1 = forward
//  step_err     out  1      sticky illegal-transition flag
//  err_cnt      out  16     QENC_ERR_CNT_EN only: saturating illegal-transition count
// BEHAVIOUR
//  - Reset: every register including the sync FFs and filtered levels = 0; all outputs 0;
//    window counter = 0.
//  - Sync: 3-FF chain per channel (q1->q2->q3).
//  - Filter (per channel):
//    - Counter increments while q3 != filtered level, clears when equal.
//    - At FILTER_LEN consecutive mismatches, filtered <= q3 and counter clears.
//    - Counter saturates; it never wraps.
//  - Decode:
//    - prev_ab register holds the last filtered {a,b}; updated every cycle.
//    - Forward sequence 00->01->11->10->00 is +1, reverse is -1.
//    - With INVERT=1 the sign is swapped and dir is inverted.
//    - No change: hold.
//    - Both bits change in one cycle: no count, dir held, step_err set.
//  - Latency: an input level change reaches rot_cnt on clk edge 4+FILTER_LEN after the edge
//    where q1 first captures it (8 edges at default). Pulses shorter than FILTER_LEN cycles
//    at q3 are discarded.
//  - Velocity:
//    - Window counter runs 0..VEL_WINDOW-1 and wraps.
//    - In its terminal cycle: rot_v <= rot_cnt_next - snap (mod 2^CNT_W); snap <= rot_cnt_next;
//      rot_v_valid = 1 on the following cycle for exactly one cycle.
//    - rot_cnt_next includes a step decoded in that same terminal cycle.
//  - Wrap: rot_cnt wraps 0x7FFF_FFFF+1 -> 0x8000_0000. rot_v is still correct across the wrap
//    (modular subtraction).
//  - err_clr and a new illegal transition in the same cycle: set wins.
//  - Reset asserted mid-window: window and snap restart from 0. The first window after reset
//    is a full VEL_WINDOW.
//  - Window FSM: ST_RUN (counting) -> ST_LATCH (1 cycle: drive rot_v_valid) -> ST_RUN.
//    rst forces ST_RUN with the counter at 0.
// CONFIGURATION
//  QENC_ERR_CNT_EN
//  - Defined: err_cnt port exists. It increments on each illegal transition and saturates
//    at 16'hFFFF. err_clr zeroes it; a simultaneous error leaves it at 1.
//  - Undefined: err_cnt port and logic are absent; step_err behaviour is unchanged.
// STRUCTURE
//  - Package qenc_pkg:
//    - typedef enum logic {ST_RUN, ST_LATCH} qenc_win_state_t
//    - QENC_FWD/QENC_REV step encodings
//    - function qenc_step(prev_ab, cur_ab) returning {legal, delta}
//  - Sub-module qenc_filter (sync chain + glitch filter, parameter FILTER_LEN), instantiated
//    once per channel.
//  - Decoder, accumulator and window FSM live in quad_encoder_if.
// TESTING
//  1. Reset, then 8 forward steps (00,01,11,10 x2) each held 20 cycles -> rot_cnt=8, dir=1,
//     step_err=0.
//  2. Single step, sa toggled at cycle 0 -> rot_cnt changes on edge 8 (FILTER_LEN=4).
//     A 3-cycle sa glitch -> rot_cnt unchanged.
//  3. VEL_WINDOW=1000; 25 forward steps inside window 1, 10 reverse in window 2
//     -> rot_v=25 then rot_v=-10 (0xFFFF_FFF6), each with one rot_v_valid pulse.
//  4. Force rot_cnt near 0x7FFF_FFFE, then 4 forward steps -> rot_cnt=0x8000_0002, next rot_v=4.
//  5. Drive ab 00->11 -> step_err=1, rot_cnt unchanged. err_clr in the same cycle as a second
//     illegal jump -> step_err stays 1. With QENC_ERR_CNT_EN: err_cnt=2, then 1 after that
//     clear cycle.
//  6. INVERT=1, forward sequence of 4 steps -> rot_cnt=-4, dir=0. Assert rst mid-window
//     -> all outputs 0, the next rot_v_valid comes exactly VEL_WINDOW+1 cycles after rst drops.

Source files
------------

// File: rtl/qenc_pkg.sv
// rtl/qenc_pkg.sv - shared types and step decode for the quadrature encoder front end
//
// Purpose: window FSM state type, step encodings and the quadrature step
//          decode function used by quad_encoder_if.
// Contents:
//   qenc_win_state_t  ST_RUN / ST_LATCH velocity window states
//   QENC_NONE/FWD/REV 2-bit step encodings (REV is -1 in two's complement)
//   qenc_step_t       {legal, delta} decode result
//   qenc_step()       decode previous/current filtered {a,b} into a step
package qenc_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_LATCH = 1'b1
    } qenc_win_state_t;

    localparam logic [1:0] QENC_NONE = 2'b00;
    localparam logic [1:0] QENC_FWD  = 2'b01;
    localparam logic [1:0] QENC_REV  = 2'b11;

    typedef struct packed {
        logic       legal;
        logic [1:0] delta;
    } qenc_step_t;

    // Position of {a,b} along the forward Gray sequence 00,01,11,10 -> 0..3.
    function automatic logic [1:0] qenc_phase(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // A phase difference of 1 is forward, 3 is reverse, 2 means both
    // channels moved at once and the direction cannot be known.
    function automatic qenc_step_t qenc_step(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
        qenc_step_t r;
        logic [1:0] diff;
        diff = qenc_phase(cur_ab) - qenc_phase(prev_ab);
        r.legal = 1'b1;
        r.delta = QENC_NONE;
        case (diff)
            2'd1:    r.delta = QENC_FWD;
            2'd3:    r.delta = QENC_REV;
            2'd2:    r.legal = 1'b0;
            default: r.delta = QENC_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qenc_filter.sv
// rtl/qenc_filter.sv - input synchroniser and glitch filter for one encoder channel
//
// Purpose: 3-FF synchroniser (q1->q2->q3) followed by a persistence filter.
//          level follows q3 only after q3 has disagreed with it for
//          FILTER_LEN consecutive counted cycles.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active high
//   din    in   raw asynchronous channel input
//   level  out  filtered channel level
module qenc_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int              CW      = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN);

    logic          q1;
    logic          q2;
    logic          q3;
    logic [CW-1:0] cnt;

    // The counter is bounded by CNT_MAX: reaching it either accepts the new
    // level (and clears) or q3 returns to level (and clears), so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1    <= 1'b0;
            q2    <= 1'b0;
            q3    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            q1 <= din;
            q2 <= q1;
            q3 <= q2;
            if (q3 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= q3;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_encoder_if.sv
// rtl/quad_encoder_if.sv - quadrature encoder front end: filter, x4 decode, count, velocity
//
// Purpose: synchronises and filters sa/sb, decodes x4 quadrature into a
//          signed wrapping rotation count, measures steps per VEL_WINDOW
//          cycles and flags illegal (double-bit) transitions.
// Optional feature macro: QENC_ERR_CNT_EN adds the saturating err_cnt output.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   sa, sb       in   encoder channels A/B, asynchronous
//   err_clr      in   clears step_err (and err_cnt)
//   rot_cnt      out  signed accumulated steps, wraps mod 2^CNT_W
//   rot_v        out  signed steps counted in the last completed window
//   rot_v_valid  out  one-cycle pulse when rot_v updates
//   dir          out  direction of last legal step, 1 = forward
//   step_err     out  sticky illegal-transition flag
//   err_cnt      out  saturating illegal-transition count (QENC_ERR_CNT_EN only)
module quad_encoder_if
    import qenc_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FILTER_LEN = 4,
    parameter int VEL_WINDOW = 100_000,
    parameter int CNT_W      = 32,
    parameter int INVERT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sa,
    input  logic             sb,
    input  logic             err_clr,
    output logic [CNT_W-1:0] rot_cnt,
    output logic [CNT_W-1:0] rot_v,
    output logic             rot_v_valid,
    output logic             dir,
    output logic             step_err
`ifdef QENC_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int              WIN_W    = $clog2(VEL_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if (CLK_FREQ < 1 || FILTER_LEN < 1 || VEL_WINDOW < 2 || CNT_W < 2) begin : g_bad_param
        $error("quad_encoder_if: parameter out of range");
    end

    logic             filt_a;
    logic             filt_b;
    logic [1:0]       cur_ab;
    logic [1:0]       prev_ab;
    qenc_step_t       step;
    logic             count_up;
    logic             count_dn;
    logic             illegal;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] rot_cnt_next;
    logic [CNT_W-1:0] snap;
    logic [WIN_W-1:0] win_cnt;
    qenc_win_state_t  win_state;

    qenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (clk),
        .rst   (rst),
        .din   (sa),
        .level (filt_a)
    );

    qenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (clk),
        .rst   (rst),
        .din   (sb),
        .level (filt_b)
    );

    assign cur_ab  = {filt_a, filt_b};
    assign rot_cnt = acc_q;

    // Mirrored motors swap which physical direction counts up.
    always_comb begin
        step     = qenc_step(prev_ab, cur_ab);
        illegal  = ~step.legal;
        count_up = 1'b0;
        count_dn = 1'b0;
        if (INVERT != 0) begin
            count_up = (step.delta == QENC_REV);
            count_dn = (step.delta == QENC_FWD);
        end else begin
            count_up = (step.delta == QENC_FWD);
            count_dn = (step.delta == QENC_REV);
        end
        rot_cnt_next = acc_q;
        if (count_up) begin
            rot_cnt_next = acc_q + ONE;
        end else if (count_dn) begin
            rot_cnt_next = acc_q - ONE;
        end
    end

    // Decoder and accumulator. acc_q is rewritten every cycle so the count
    // always reflects rot_cnt_next.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab  <= 2'b00;
            acc_q    <= '0;
            dir      <= 1'b0;
            step_err <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            acc_q   <= rot_cnt_next;
            if (count_up || count_dn) begin
                dir <= count_up;
            end
            // A new illegal transition outranks a clear in the same cycle.
            if (illegal) begin
                step_err <= 1'b1;
            end else if (err_clr) begin
                step_err <= 1'b0;
            end
        end
    end

`ifdef QENC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'h0000;
        end else if (err_clr) begin
            err_cnt <= illegal ? 16'h0001 : 16'h0000;
        end else if (illegal && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end
`endif

    // Velocity window. The counter free-runs so every window is exactly
    // VEL_WINDOW cycles; the FSM only marks the cycle after the terminal one.
    // rot_cnt_next is used so a step decoded in the terminal cycle lands in
    // this window rather than the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            win_state   <= ST_RUN;
            snap        <= '0;
            rot_v       <= '0;
            rot_v_valid <= 1'b0;
        end else begin
            if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                rot_v   <= rot_cnt_next - snap;
                snap    <= rot_cnt_next;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
            case (win_state)
                ST_RUN: begin
                    if (win_cnt == WIN_LAST) begin
                        win_state   <= ST_LATCH;
                        rot_v_valid <= 1'b1;
                    end else begin
                        rot_v_valid <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    win_state   <= ST_RUN;
                    rot_v_valid <= 1'b0;
                end
                default: begin
                    win_state   <= ST_RUN;
                    rot_v_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_if.sv
// tb/tb_quad_encoder_if.sv - directed self-checking bench for quad_encoder_if
module tb_quad_encoder_if;

    localparam int VW = 1000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, sa0, sb0, clr0;
    logic [31:0] cnt0, v0;
    logic        vv0, dir0, err0;
    logic        rst1, sa1, sb1, clr1;
    logic [31:0] cnt1, v1;
    logic        vv1, dir1, err1;
`ifdef QENC_ERR_CNT_EN
    logic [15:0] ec0, ec1;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  ab0;
    logic [1:0]  ab1;
    logic [31:0] exp_cnt0;
    int          cyc;
    logic        seen;

    quad_encoder_if #(.FILTER_LEN(4), .VEL_WINDOW(VW), .CNT_W(32), .INVERT(0)) dut0 (
        .clk         (clk),
        .rst         (rst0),
        .sa          (sa0),
        .sb          (sb0),
        .err_clr     (clr0),
        .rot_cnt     (cnt0),
        .rot_v       (v0),
        .rot_v_valid (vv0),
        .dir         (dir0),
        .step_err    (err0)
`ifdef QENC_ERR_CNT_EN
        ,
        .err_cnt     (ec0)
`endif
    );

    quad_encoder_if #(.FILTER_LEN(4), .VEL_WINDOW(VW), .CNT_W(32), .INVERT(1)) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .sa          (sa1),
        .sb          (sb1),
        .err_clr     (clr1),
        .rot_cnt     (cnt1),
        .rot_v       (v1),
        .rot_v_valid (vv1),
        .dir         (dir1),
        .step_err    (err1)
`ifdef QENC_ERR_CNT_EN
        ,
        .err_cnt     (ec1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Called at a negedge; holds the new level for 20 cycles.
    task automatic drive0(input logic [1:0] ab);
        sa0 = ab[1];
        sb0 = ab[0];
        repeat (20) @(negedge clk);
    endtask

    task automatic drive1(input logic [1:0] ab);
        sa1 = ab[1];
        sb1 = ab[0];
        repeat (20) @(negedge clk);
    endtask

    // Waits (bounded) for a dut0 rot_v_valid pulse and checks it against the
    // oldest scoreboard entry, then checks the pulse lasted one cycle.
    task automatic wait_valid0(input string tag);
        logic        got;
        logic [31:0] exp;
        got = 1'b0;
        for (int i = 0; i < 2 * VW; i++) begin
            @(negedge clk);
            if (vv0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check(tag, v0, exp);
            @(negedge clk);
            check({tag, "_pulse"}, {31'd0, vv0}, 32'd0);
        end
    endtask

    initial begin
        rst0 = 1'b1; sa0 = 1'b0; sb0 = 1'b0; clr0 = 1'b0;
        rst1 = 1'b1; sa1 = 1'b0; sb1 = 1'b0; clr1 = 1'b0;
        ab0 = 2'b00; ab1 = 2'b00; exp_cnt0 = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cnt", cnt0, 32'd0);
        check("rst_v", v0, 32'd0);
        check("rst_valid", {31'd0, vv0}, 32'd0);
        check("rst_dir", {31'd0, dir0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // 1: eight forward steps
        for (int i = 0; i < 8; i++) begin
            ab0 = fwd(ab0);
            exp_cnt0 = exp_cnt0 + 32'd1;
            drive0(ab0);
        end
        check("fwd8_cnt", cnt0, 32'd8);
        check("fwd8_dir", {31'd0, dir0}, 32'd1);
        check("fwd8_err", {31'd0, err0}, 32'd0);

        // 2: latency of a single sa edge (00 -> 10 is one reverse step)
        sa0 = 1'b1;
        ab0 = 2'b10;
        repeat (8) @(negedge clk);
        check("lat_edge7_hold", cnt0, 32'd8);
        @(negedge clk);
        check("lat_edge8_cnt", cnt0, 32'd7);
        check("lat_dir", {31'd0, dir0}, 32'd0);
        // 3-cycle glitch on sa is rejected
        sa0 = 1'b0;
        repeat (3) @(negedge clk);
        sa0 = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_cnt", cnt0, 32'd7);
        ab0 = fwd(ab0);
        drive0(ab0);
        check("back_cnt", cnt0, 32'd8);

        // 3: velocity windows, restarted by a reset pulse
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("rerst_cnt", cnt0, 32'd0);
        exp_q.push_back(32'd25);
        for (int i = 0; i < 25; i++) begin
            ab0 = fwd(ab0);
            drive0(ab0);
        end
        wait_valid0("win1_v");
        exp_q.push_back(32'hFFFF_FFF6);
        for (int i = 0; i < 10; i++) begin
            ab0 = rev(ab0);
            drive0(ab0);
        end
        check("win2_cnt", cnt0, 32'd15);
        wait_valid0("win2_v");

        // 4: wrap through 0x7FFF_FFFF
        force dut0.acc_q = 32'h7FFF_FFFE;
        @(negedge clk);
        release dut0.acc_q;
        @(negedge clk);
        exp_q.push_back(32'h7FFF_FFFE - 32'd15);
        wait_valid0("win3_v");
        exp_q.push_back(32'd4);
        for (int i = 0; i < 4; i++) begin
            ab0 = fwd(ab0);
            drive0(ab0);
        end
        check("wrap_cnt", cnt0, 32'h8000_0002);
        wait_valid0("win4_v");

        // 5: illegal transitions and err_clr priority
        ab0 = {~ab0[1], ~ab0[0]};
        drive0(ab0);
        check("ill1_err", {31'd0, err0}, 32'd1);
        check("ill1_cnt", cnt0, 32'h8000_0002);
`ifdef QENC_ERR_CNT_EN
        check("ill1_ecnt", {16'd0, ec0}, 32'd1);
`endif
        ab0 = {~ab0[1], ~ab0[0]};
        drive0(ab0);
`ifdef QENC_ERR_CNT_EN
        check("ill2_ecnt", {16'd0, ec0}, 32'd2);
`endif
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("clr_err", {31'd0, err0}, 32'd0);
        // q1 captures at edge 0, the illegal jump is registered at edge 8
        ab0 = {~ab0[1], ~ab0[0]};
        sa0 = ab0[1];
        sb0 = ab0[0];
        repeat (8) @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("setwins_err", {31'd0, err0}, 32'd1);
        check("setwins_cnt", cnt0, 32'h8000_0002);
`ifdef QENC_ERR_CNT_EN
        check("setwins_ecnt", {16'd0, ec0}, 32'd1);
`endif
        repeat (20) @(negedge clk);

        // 6: inverted channel and mid-window reset
        for (int i = 0; i < 4; i++) begin
            ab1 = fwd(ab1);
            drive1(ab1);
        end
        check("inv_cnt", cnt1, 32'hFFFF_FFFC);
        check("inv_dir", {31'd0, dir1}, 32'd0);
        rst1 = 1'b1;
        @(negedge clk);
        check("inv_rst_cnt", cnt1, 32'd0);
        check("inv_rst_v", v1, 32'd0);
        check("inv_rst_valid", {31'd0, vv1}, 32'd0);
        check("inv_rst_dir", {31'd0, dir1}, 32'd0);
        check("inv_rst_err", {31'd0, err1}, 32'd0);
        rst1 = 1'b0;
        // cycle 1 is the first clock period with rst low
        cyc = 1;
        seen = 1'b0;
        while (cyc <= 2 * VW && !seen) begin
            @(negedge clk);
            cyc++;
            if (vv1) seen = 1'b1;
        end
        check("inv_first_valid_cycle", cyc, VW + 1);
        check("inv_first_v", v1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
